// File: rtl/sr_latch_pkg.sv
// Shared definitions for the SR latch bank: per-cell state encoding and the
// decode/transition helpers used by every storage cell.
package sr_latch_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_SET       = 2'd1,
    ST_FORBIDDEN = 2'd2
  } cell_state_t;

  function automatic logic state_to_q(input cell_state_t st);
    logic q;
    case (st)
      ST_SET:       q = 1'b1;
      ST_RESET:     q = 1'b0;
      ST_FORBIDDEN: q = 1'b0;
      default:      q = 1'b0;
    endcase
    return q;
  endfunction

  // Qn follows NOR-latch behaviour: both rails low while forbidden.
  function automatic logic state_to_qn(input cell_state_t st);
    logic qn;
    case (st)
      ST_SET:       qn = 1'b0;
      ST_RESET:     qn = 1'b1;
      ST_FORBIDDEN: qn = 1'b0;
      default:      qn = 1'b1;
    endcase
    return qn;
  endfunction

  function automatic cell_state_t next_state(input cell_state_t cur, input logic s, input logic r);
    cell_state_t nxt;
    case ({s, r})
      2'b10:   nxt = ST_SET;
      2'b01:   nxt = ST_RESET;
      2'b11:   nxt = ST_FORBIDDEN;
      2'b00:   nxt = (cur == ST_FORBIDDEN) ? ST_RESET : cur;
      default: nxt = ST_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One clocked SR storage cell; Q, Qn and the forbidden flag are all flops
// loaded from the decoded next state.
module sr_cell
  import sr_latch_pkg::*;
#(
  parameter logic RESET_Q = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_s,
  input  logic i_r,
  output logic o_q,
  output logic o_qn,
  output logic o_forbidden
);

  localparam cell_state_t RST_STATE = RESET_Q ? ST_SET : ST_RESET;

  cell_state_t r_state;
  cell_state_t w_next;
  logic        r_q;
  logic        r_qn;
  logic        r_forbidden;

  // Next-state decode from the sampled set/reset requests.
  always_comb begin
    w_next = r_state;
    if (i_rst_n) begin
      w_next = next_state(r_state, i_s, i_r);
    end else begin
      w_next = RST_STATE;
    end
  end

  // State and output registers; reset has priority over S/R.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= RST_STATE;
      r_q         <= RESET_Q;
      r_qn        <= ~RESET_Q;
      r_forbidden <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_q         <= state_to_q(w_next);
      r_qn        <= state_to_qn(w_next);
      r_forbidden <= (w_next == ST_FORBIDDEN);
    end
  end

  assign o_q         = r_q;
  assign o_qn        = r_qn;
  assign o_forbidden = r_forbidden;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of WIDTH independent SR cells with a sticky error flag raised whenever
// any cell enters or stays in the forbidden state.
module sr_latch_bank
  import sr_latch_pkg::*;
#(
  parameter int   WIDTH   = 1,
  parameter logic RESET_Q = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_s,
  input  logic [WIDTH-1:0] i_r,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qn,
  output logic [WIDTH-1:0] o_forbidden,
  output logic             o_err
);

  logic r_err;
  logic w_any_forbidden;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    sr_cell #(
      .RESET_Q (RESET_Q)
    ) u_cell (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_s         (i_s[g]),
      .i_r         (i_r[g]),
      .o_q         (o_q[g]),
      .o_qn        (o_qn[g]),
      .o_forbidden (o_forbidden[g])
    );
  end

  // S=R=1 is exactly the condition that loads FORBIDDEN on this edge, so the
  // sticky flag rises together with the cell's forbidden output.
  assign w_any_forbidden = |(i_s & i_r);

  // Sticky error register, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_any_forbidden;
    end
  end

  assign o_err = r_err;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed scoreboard bench: three bank configurations driven in lockstep,
// expectations queued at drive time and checked one edge later.
module tb_sr_latch_bank;

  typedef struct {
    logic [3:0] q;
    logic [3:0] qn;
    logic [3:0] f;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] s1, r1;
  logic [3:0] cs, cr;
  logic [0:0] a_q, a_qn, a_f, b_q, b_qn, b_f;
  logic [3:0] c_q, c_qn, c_f;
  logic       a_err, b_err, c_err;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t sb_c[$];
  exp_t st_a, st_b, st_c;

  always #5 clk = ~clk;

  sr_latch_bank #(.WIDTH(1), .RESET_Q(1'b0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_s(s1), .i_r(r1),
    .o_q(a_q), .o_qn(a_qn), .o_forbidden(a_f), .o_err(a_err)
  );

  sr_latch_bank #(.WIDTH(1), .RESET_Q(1'b1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_s(s1), .i_r(r1),
    .o_q(b_q), .o_qn(b_qn), .o_forbidden(b_f), .o_err(b_err)
  );

  sr_latch_bank #(.WIDTH(4), .RESET_Q(1'b0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_s(cs), .i_r(cr),
    .o_q(c_q), .o_qn(c_qn), .o_forbidden(c_f), .o_err(c_err)
  );

  // Reference behaviour of a bank of SR cells for one clock edge.
  function automatic exp_t model(input exp_t p, input logic rn, input logic [3:0] s,
                                 input logic [3:0] r, input int w, input logic rq);
    exp_t n;
    n.q   = 4'b0000;
    n.qn  = 4'b0000;
    n.f   = 4'b0000;
    n.err = 1'b0;
    for (int i = 0; i < w; i++) begin
      if (!rn) begin
        n.q[i] = rq;
        n.f[i] = 1'b0;
      end else if (s[i] && !r[i]) begin
        n.q[i] = 1'b1;
        n.f[i] = 1'b0;
      end else if (!s[i] && r[i]) begin
        n.q[i] = 1'b0;
        n.f[i] = 1'b0;
      end else if (s[i] && r[i]) begin
        n.q[i] = 1'b0;
        n.f[i] = 1'b1;
      end else begin
        n.q[i] = p.f[i] ? 1'b0 : p.q[i];
        n.f[i] = 1'b0;
      end
      n.qn[i] = n.f[i] ? 1'b0 : ~n.q[i];
    end
    n.err = rn ? (p.err | (|(s & r))) : 1'b0;
    return n;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, expv);
    end
  endtask

  task automatic step(input logic rn, input logic s, input logic r,
                      input logic [3:0] s4, input logic [3:0] r4);
    exp_t e;
    step_no++;
    st_a = model(st_a, rn, {3'b000, s}, {3'b000, r}, 1, 1'b0);
    st_b = model(st_b, rn, {3'b000, s}, {3'b000, r}, 1, 1'b1);
    st_c = model(st_c, rn, s4, r4, 4, 1'b0);
    sb_a.push_back(st_a);
    sb_b.push_back(st_b);
    sb_c.push_back(st_c);
    rst_n = rn;
    s1    = s;
    r1    = r;
    cs    = s4;
    cr    = r4;
    @(posedge clk);
    #1;
    e = sb_a.pop_front();
    check("a_q",   {3'b000, a_q},   e.q);
    check("a_qn",  {3'b000, a_qn},  e.qn);
    check("a_f",   {3'b000, a_f},   e.f);
    check("a_err", {3'b000, a_err}, {3'b000, e.err});
    e = sb_b.pop_front();
    check("b_q",   {3'b000, b_q},   e.q);
    check("b_qn",  {3'b000, b_qn},  e.qn);
    check("b_f",   {3'b000, b_f},   e.f);
    check("b_err", {3'b000, b_err}, {3'b000, e.err});
    e = sb_c.pop_front();
    check("c_q",   c_q,   e.q);
    check("c_qn",  c_qn,  e.qn);
    check("c_f",   c_f,   e.f);
    check("c_err", {3'b000, c_err}, {3'b000, e.err});
  endtask

  initial begin
    st_a = '{q: 4'b0000, qn: 4'b0000, f: 4'b0000, err: 1'b0};
    st_b = st_a;
    st_c = st_a;
    rst_n = 1'b0;
    s1 = 1'b0;
    r1 = 1'b0;
    cs = 4'b0000;
    cr = 4'b0000;
    @(negedge clk);
    // reset while S=R=1 must win
    step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111);
    step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111);
    step(1'b1, 1'b1, 1'b0, 4'b0101, 4'b0011);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 4'b1010, 4'b0101);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    step(1'b1, 1'b0, 1'b1, 4'b1100, 4'b0110);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 4'b0011, 4'b0000);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 4'b1001, 4'b1001);
    step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0001);
    // reset mid-operation
    step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111);
    step(1'b1, 1'b1, 1'b1, 4'b0001, 4'b0001);
    // reset while a cell is forbidden
    step(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0001);
    step(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_latch_bank.md
SR_LATCH_BANK -- requirements
Module: sr_latch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the number of independent SR storage cells.
REQ-002 The block SHALL have parameter RESET_Q, default 1'b0, giving the Q value of every cell after reset.
REQ-003 The block SHALL have exactly one clock and a synchronous, active-low reset.
REQ-004 Port i_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 Port i_rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 Port i_s, input, WIDTH bits: set request, one bit per cell.
REQ-007 Port i_r, input, WIDTH bits: reset request, one bit per cell.
REQ-008 Port o_q, output, WIDTH bits: stored Q per cell.
REQ-009 Port o_qn, output, WIDTH bits: complementary output per cell (NOR-latch semantics, not simply ~o_q).
REQ-010 Port o_forbidden, output, WIDTH bits: high while the matching cell is in the forbidden state.
REQ-011 Port o_err, output, 1 bit: sticky flag, set when any cell enters the forbidden state.

Function
REQ-012 Each cell SHALL update independently on the rising edge of i_clk, one cycle after sampling i_s/i_r; all outputs SHALL be registered, with no combinational input-to-output path.
REQ-013 If S=1 and R=0, the cell SHALL go to SET: Q=1, Qn=0.
REQ-014 If S=0 and R=1, the cell SHALL go to RESET: Q=0, Qn=1.
REQ-015 If S=0 and R=0, the cell SHALL hold its state: Q and Qn unchanged.
REQ-016 If S=1 and R=1, the cell SHALL go to FORBIDDEN: Q=0, Qn=0, o_forbidden bit = 1.
REQ-017 Leaving FORBIDDEN:
- S=R=0 SHALL resolve deterministically to RESET (Q=0, Qn=1, o_forbidden bit = 0).
- S=1,R=0 SHALL go to SET.
- S=0,R=1 SHALL go to RESET.
REQ-018 Except in FORBIDDEN, o_qn SHALL equal ~o_q.
REQ-019 o_err SHALL go to 1 on the edge where any cell enters or stays in FORBIDDEN, and SHALL stay 1 until reset.
REQ-020 When several cells change on the same edge, each cell SHALL follow its own S/R bits; there SHALL be no cross-cell interaction other than o_err.

Reset
REQ-021 When i_rst_n=0 at a rising edge, every cell SHALL load o_q=RESET_Q and o_qn=~RESET_Q.
REQ-022 On that same reset edge, o_forbidden SHALL be 0 and o_err SHALL be 0.
REQ-023 Reset SHALL take priority over i_s/i_r, including mid-operation and while a cell is in FORBIDDEN.
REQ-024 The outputs SHALL change only on a clock edge; there SHALL be no asynchronous reset path.

Structure
REQ-025 A shared package sr_latch_pkg SHALL hold:
- the cell-state enum: ST_RESET, ST_SET, ST_FORBIDDEN;
- the functions that decode state to Q and to Qn.
REQ-026 Each bit SHALL be implemented by one sub-module, sr_cell (clock, reset, s, r -> q, qn, forbidden), instantiated WIDTH times in a generate loop.
REQ-027 The top level SHALL add only the o_err OR-reduction and the sticky register.

Verification (WIDTH=1, RESET_Q=0 unless noted)
REQ-028 Reset then R=1,S=0 -> after one edge Q=0, Qn=1, o_forbidden=0.
REQ-029 S=1,R=0 -> Q=1, Qn=0; then S=R=0 for 3 cycles -> Q stays 1, Qn stays 0.
REQ-030 R=1,S=0 -> Q=0, Qn=1; then S=R=0 -> Q stays 0, Qn stays 1.
REQ-031 S=R=1 -> Q=0, Qn=0, o_forbidden=1, o_err=1; then S=R=0 -> Q=0, Qn=1, o_forbidden=0, o_err stays 1.
REQ-032 i_rst_n=0 with S=R=1, held for one edge -> Q=0, Qn=1, o_err=0; with RESET_Q=1 -> Q=1, Qn=0.
REQ-033 WIDTH=4, S=4'b0101, R=4'b0011 -> Q=4'b0100, Qn=4'b1010, o_forbidden=4'b0001, o_err=1.
